// File: rtl/window_scan_if.sv
// Handshake and buffer-control bundle between the window scan controller
// (master) and the surrounding feature-map buffer / stream logic (slave).
interface window_scan_if;
  logic        start;
  logic        src_valid;
  logic        src_ready;
  logic        buf_en;
  logic [31:0] buf_addr;
  logic [3:0]  buf_k;
  logic [3:0]  buf_q;
  logic        win_valid;
  logic        win_ready;
  logic        win_last;
  logic        busy;
  logic        done;

  modport master (
    input  start, src_valid, win_ready,
    output src_ready, buf_en, buf_addr, buf_k, buf_q,
           win_valid, win_last, busy, done
  );

  modport slave (
    output start, src_valid, win_ready,
    input  src_ready, buf_en, buf_addr, buf_k, buf_q,
           win_valid, win_last, busy, done
  );
endinterface

// File: rtl/window_scan_ctrl.sv
// Window scan controller: loads an N x N byte feature map into a word
// buffer, then walks a W x W window over it in row-major order, inserting
// one FETCH bubble before each window to cover the buffer's registered read.
module window_scan_ctrl #(
  parameter int N     = 13,
  parameter int W     = 4,
  parameter int WORDS = 43
) (
  input  logic         clk,
  input  logic         rst,
  window_scan_if.master bus
);

  localparam int          L         = N - W;
  localparam logic [3:0]  LIM       = 4'(L);
  localparam logic [31:0] LAST_ADDR = 32'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [3:0]  k_reg;
  logic [3:0]  q_reg;
  logic        src_ready_reg;
  logic        win_valid_reg;
  logic        win_last_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        accept;

  // A word is written whenever upstream offers one and we are loading.
  assign accept = bus.src_valid & src_ready_reg;

  // Frame sequencing: state, counters and all registered outputs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      k_reg         <= '0;
      q_reg         <= '0;
      src_ready_reg <= 1'b0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg     <= LOAD;
            addr_reg      <= '0;
            src_ready_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end

        LOAD: begin
          if (accept) begin
            if (addr_reg == LAST_ADDR) begin
              // Last word written: address parks at the final word.
              state_reg     <= FETCH;
              src_ready_reg <= 1'b0;
              k_reg         <= '0;
              q_reg         <= '0;
            end else begin
              addr_reg <= addr_reg + 32'd1;
            end
          end
        end

        FETCH: begin
          // Buffer read for (k, q) lands at the end of this cycle.
          state_reg     <= PRESENT;
          win_valid_reg <= 1'b1;
          win_last_reg  <= (k_reg == LIM) && (q_reg == LIM);
        end

        PRESENT: begin
          // Origin is held until downstream takes the window.
          if (bus.win_ready) begin
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            if (q_reg < LIM) begin
              q_reg     <= q_reg + 4'd1;
              state_reg <= FETCH;
            end else if (k_reg < LIM) begin
              q_reg     <= '0;
              k_reg     <= k_reg + 4'd1;
              state_reg <= FETCH;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg     <= IDLE;
          src_ready_reg <= 1'b0;
          win_valid_reg <= 1'b0;
          win_last_reg  <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.src_ready = src_ready_reg;
  assign bus.buf_en    = accept;
  assign bus.buf_addr  = addr_reg;
  assign bus.buf_k     = k_reg;
  assign bus.buf_q     = q_reg;
  assign bus.win_valid = win_valid_reg;
  assign bus.win_last  = win_last_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: reset, full-rate frame,
// gapped load with random back-pressure, fixed back-pressure and abort.
module tb_window_scan_ctrl;

  localparam int N      = 13;
  localparam int W      = 4;
  localparam int WORDS  = 43;
  localparam int L      = N - W;
  localparam int NWIN   = (L + 1) * (L + 1);

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  window_scan_if bus ();

  window_scan_ctrl #(.N(N), .W(W), .WORDS(WORDS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a frame and stream all words at full rate; leaves the DUT in FETCH.
  task automatic load_frame;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.src_valid = 1'b1;
    repeat (WORDS) tick;
    bus.src_valid = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.src_valid = 1'b1;
    n = $urandom_range(3, 40);
    repeat (n) tick;
    rst = 1'b1;
    tick;
    bus.start = 1'b1;   // start together with reset must lose
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    tests++; if (bus.buf_addr !== 32'd0) begin fails++; $display("FAIL rst_addr got=%0d exp=0", bus.buf_addr); end
    tests++; if (bus.buf_k !== 4'd0) begin fails++; $display("FAIL rst_k got=%0d exp=0", bus.buf_k); end
    tests++; if (bus.buf_q !== 4'd0) begin fails++; $display("FAIL rst_q got=%0d exp=0", bus.buf_q); end
    tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL rst_win_valid got=%0b exp=0", bus.win_valid); end
    tests++; if (bus.win_last !== 1'b0) begin fails++; $display("FAIL rst_win_last got=%0b exp=0", bus.win_last); end
    tests++; if (bus.src_ready !== 1'b0) begin fails++; $display("FAIL rst_src_ready got=%0b exp=0", bus.src_ready); end
    tests++; if (bus.buf_en !== 1'b0) begin fails++; $display("FAIL rst_buf_en got=%0b exp=0", bus.buf_en); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done got=%0b exp=0", bus.done); end
    bus.start = 1'b0;
    bus.src_valid = 1'b0;
    rst = 1'b0;
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy got=%0b exp=0", bus.busy); end
    $display("[TB] test_reset: reset after %0d load cycles", n);
  endtask

  task automatic test_full_frame;
    int  cyc;
    int  widx;
    bit  exp_v;
    bus.win_ready = 1'b1;
    bus.src_valid = 1'b0;
    bus.start = 1'b1;
    tick;                 // start edge
    bus.src_valid = 1'b1; // start stays high: must be ignored outside IDLE
    #1;
    cyc = 0;
    tests++; if (bus.src_ready !== 1'b1) begin fails++; $display("FAIL full_src_ready got=%0b exp=1", bus.src_ready); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL full_busy got=%0b exp=1", bus.busy); end
    for (int i = 0; i < WORDS; i++) begin
      tests++; if (bus.buf_en !== 1'b1) begin fails++; $display("FAIL full_buf_en word=%0d got=%0b exp=1", i, bus.buf_en); end
      tests++; if (bus.buf_addr !== 32'(i)) begin fails++; $display("FAIL full_addr got=%0d exp=%0d", bus.buf_addr, i); end
      tick;
      cyc++;
    end
    // First cycle after the load is the FETCH bubble for (0,0).
    tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL full_fetch_valid got=%0b exp=0", bus.win_valid); end
    tests++; if (bus.src_ready !== 1'b0) begin fails++; $display("FAIL full_fetch_src_ready got=%0b exp=0", bus.src_ready); end
    tests++; if (bus.buf_en !== 1'b0) begin fails++; $display("FAIL full_fetch_buf_en got=%0b exp=0", bus.buf_en); end
    tests++; if (bus.buf_k !== 4'd0 || bus.buf_q !== 4'd0) begin fails++; $display("FAIL full_fetch_kq got=(%0d,%0d) exp=(0,0)", bus.buf_k, bus.buf_q); end
    tests++; if (bus.buf_addr !== 32'(WORDS - 1)) begin fails++; $display("FAIL full_fetch_addr got=%0d exp=%0d", bus.buf_addr, WORDS - 1); end
    bus.src_valid = 1'b0;
    widx = 0;
    // 43 load cycles, then 100 x (FETCH, PRESENT), then DONE as the 244th cycle.
    while (cyc < 245) begin
      tick;
      cyc++;
      if (cyc >= 244) bus.start = 1'b0;
      exp_v = (cyc >= 44) && (cyc <= 42 + 2 * NWIN) && (((cyc - 44) % 2) == 0);
      tests++; if (bus.win_valid !== exp_v) begin fails++; $display("FAIL full_valid cyc=%0d got=%0b exp=%0b", cyc, bus.win_valid, exp_v); end
      if (bus.win_valid === 1'b1) begin
        tests++; if (bus.buf_k !== 4'(widx / (L + 1)) || bus.buf_q !== 4'(widx % (L + 1))) begin fails++; $display("FAIL full_kq win=%0d got=(%0d,%0d) exp=(%0d,%0d)", widx, bus.buf_k, bus.buf_q, widx / (L + 1), widx % (L + 1)); end
        tests++; if (bus.win_last !== (widx == NWIN - 1)) begin fails++; $display("FAIL full_last win=%0d got=%0b", widx, bus.win_last); end
        widx++;
      end else begin
        tests++; if (bus.win_last !== 1'b0) begin fails++; $display("FAIL full_last_idle cyc=%0d got=%0b exp=0", cyc, bus.win_last); end
      end
      tests++; if (bus.done !== (cyc == 243)) begin fails++; $display("FAIL full_done cyc=%0d got=%0b exp=%0b", cyc, bus.done, cyc == 243); end
      tests++; if (bus.busy !== (cyc <= 243)) begin fails++; $display("FAIL full_busy cyc=%0d got=%0b exp=%0b", cyc, bus.busy, cyc <= 243); end
      tests++; if (bus.src_ready !== 1'b0) begin fails++; $display("FAIL full_scan_src_ready cyc=%0d got=%0b exp=0", cyc, bus.src_ready); end
    end
    tests++; if (widx != NWIN) begin fails++; $display("FAIL full_win_count got=%0d exp=%0d", widx, NWIN); end
    $display("[TB] test_full_frame: %0d windows", widx);
  endtask

  task automatic test_gapped_random;
    int acc;
    int idx;
    int guard;
    bit prev_cons;
    bit seen_done;
    bus.win_ready = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    acc = 0;
    for (int j = 0; j < 2 * WORDS; j++) begin
      bus.src_valid = (j % 2 == 1);
      #1;
      tests++; if (bus.src_ready !== 1'b1) begin fails++; $display("FAIL gap_src_ready j=%0d got=%0b exp=1", j, bus.src_ready); end
      tests++; if (bus.buf_en !== bus.src_valid) begin fails++; $display("FAIL gap_buf_en j=%0d got=%0b exp=%0b", j, bus.buf_en, bus.src_valid); end
      tests++; if (bus.buf_addr !== 32'(acc)) begin fails++; $display("FAIL gap_addr j=%0d got=%0d exp=%0d", j, bus.buf_addr, acc); end
      if (bus.src_valid) acc++;
      tick;
    end
    bus.src_valid = 1'b0;
    #1;
    tests++; if (bus.src_ready !== 1'b0) begin fails++; $display("FAIL gap_end_src_ready got=%0b exp=0", bus.src_ready); end
    tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL gap_fetch_valid got=%0b exp=0", bus.win_valid); end
    tests++; if (bus.buf_addr !== 32'(WORDS - 1)) begin fails++; $display("FAIL gap_end_addr got=%0d exp=%0d", bus.buf_addr, WORDS - 1); end
    idx = 0;
    prev_cons = 1'b0;
    seen_done = 1'b0;
    guard = 0;
    while (!seen_done && guard < 3000) begin
      bus.win_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_cons) begin
        if (idx < NWIN) begin
          tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL gap_bubble win=%0d got=%0b exp=0", idx, bus.win_valid); end
        end else begin
          tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL gap_done got=%0b exp=1", bus.done); end
        end
      end
      if (bus.win_valid === 1'b1) begin
        tests++; if (bus.buf_k !== 4'(idx / (L + 1)) || bus.buf_q !== 4'(idx % (L + 1))) begin fails++; $display("FAIL gap_kq win=%0d got=(%0d,%0d) exp=(%0d,%0d)", idx, bus.buf_k, bus.buf_q, idx / (L + 1), idx % (L + 1)); end
        tests++; if (bus.win_last !== (idx == NWIN - 1)) begin fails++; $display("FAIL gap_last win=%0d got=%0b", idx, bus.win_last); end
      end
      if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        tests++; if (idx != NWIN) begin fails++; $display("FAIL gap_done_early windows=%0d exp=%0d", idx, NWIN); end
      end
      prev_cons = (bus.win_valid === 1'b1) && bus.win_ready;
      if (prev_cons) idx++;
      tick;
      guard++;
    end
    tests++; if (!seen_done) begin fails++; $display("FAIL gap_timeout done got=0 exp=1 within 3000 cycles"); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL gap_idle_busy got=%0b exp=0", bus.busy); end
    $display("[TB] test_gapped_random: %0d windows in %0d scan cycles", idx, guard);
  endtask

  task automatic test_back_pressure;
    bit found;
    bit seen_done;
    bus.win_ready = 1'b1;
    load_frame;
    found = 1'b0;
    for (int g = 0; g < 500; g++) begin
      if (bus.win_valid === 1'b0 && bus.busy === 1'b1 && bus.buf_k === 4'd3 && bus.buf_q === 4'd7) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL bp_reach window (3,7) got=not-reached exp=reached");
    end else begin
      bus.win_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
        tick;
        tests++; if (bus.win_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid c=%0d got=%0b exp=1", c, bus.win_valid); end
        tests++; if (bus.buf_k !== 4'd3 || bus.buf_q !== 4'd7) begin fails++; $display("FAIL bp_hold_kq c=%0d got=(%0d,%0d) exp=(3,7)", c, bus.buf_k, bus.buf_q); end
      end
      bus.win_ready = 1'b1;
      tick;
      tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL bp_fetch_valid got=%0b exp=0", bus.win_valid); end
      tests++; if (bus.buf_k !== 4'd3 || bus.buf_q !== 4'd8) begin fails++; $display("FAIL bp_next_kq got=(%0d,%0d) exp=(3,8)", bus.buf_k, bus.buf_q); end
      tick;
      tests++; if (bus.win_valid !== 1'b1 || bus.win_last !== 1'b0) begin fails++; $display("FAIL bp_next_present got valid=%0b last=%0b exp valid=1 last=0", bus.win_valid, bus.win_last); end
    end
    seen_done = 1'b0;
    for (int g = 0; g < 500 && !seen_done; g++) begin
      tick;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    tests++; if (!seen_done) begin fails++; $display("FAIL bp_timeout done got=0 exp=1 within 500 cycles"); end
    tick;
    $display("[TB] test_back_pressure: window (3,7) held 6 cycles");
  endtask

  task automatic test_abort;
    bit found;
    bus.win_ready = 1'b1;
    load_frame;
    found = 1'b0;
    for (int g = 0; g < 500; g++) begin
      if (bus.win_valid === 1'b0 && bus.busy === 1'b1 && bus.buf_k === 4'd5 && bus.buf_q === 4'd2) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    tests++; if (!found) begin fails++; $display("FAIL abort_reach window (5,2) got=not-reached exp=reached"); end
    bus.win_ready = 1'b0;
    tick;
    tests++; if (bus.win_valid !== 1'b1 || bus.buf_k !== 4'd5 || bus.buf_q !== 4'd2) begin fails++; $display("FAIL abort_present got valid=%0b (%0d,%0d) exp valid=1 (5,2)", bus.win_valid, bus.buf_k, bus.buf_q); end
    rst = 1'b1;
    tick;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%0b exp=0", bus.busy); end
    tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL abort_win_valid got=%0b exp=0", bus.win_valid); end
    tests++; if (bus.buf_k !== 4'd0 || bus.buf_q !== 4'd0) begin fails++; $display("FAIL abort_kq got=(%0d,%0d) exp=(0,0)", bus.buf_k, bus.buf_q); end
    rst = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL abort_restart_busy got=%0b exp=1", bus.busy); end
    tests++; if (bus.src_ready !== 1'b1) begin fails++; $display("FAIL abort_restart_src_ready got=%0b exp=1", bus.src_ready); end
    tests++; if (bus.buf_addr !== 32'd0) begin fails++; $display("FAIL abort_restart_addr got=%0d exp=0", bus.buf_addr); end
    bus.src_valid = 1'b1;
    #1;
    tests++; if (bus.buf_en !== 1'b1) begin fails++; $display("FAIL abort_restart_buf_en got=%0b exp=1", bus.buf_en); end
    repeat (3) tick;
    tests++; if (bus.buf_addr !== 32'd3) begin fails++; $display("FAIL abort_reload_addr got=%0d exp=3", bus.buf_addr); end
    rst = 1'b1;
    bus.src_valid = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    $display("[TB] test_abort: aborted at (5,2), reload restarted at word 0");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.src_valid = 1'b0;
    bus.win_ready = 1'b0;
    repeat (2) tick;
    test_reset;
    test_full_frame;
    test_gapped_random;
    test_back_pressure;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
